// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier with its own controller for the EX-stage MUL.
// Latency: accept cycle + WIDTH/UNROLL RUN cycles, then a one-cycle DONE pulse.
// Backpressure: Stall freezes the pipeline from accept through the last RUN cycle.
module mul_sequencer #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] step_mcand, step_mplier, step_acc;
  logic             last_step;

  // One RUN cycle of work: retire UNROLL multiplier bits, LSB first, modulo 2^WIDTH.
  always_comb begin
    step_mcand  = mcand_q;
    step_mplier = mplier_q;
    step_acc    = acc_q;
    for (int i = 0; i < UNROLL; i++) begin
      if (step_mplier[0]) begin
        step_acc = step_acc + step_mcand;
      end
      step_mcand  = step_mcand << 1;
      step_mplier = step_mplier >> 1;
    end
  end

  assign last_step = (cnt_q == CW'(N - 1));

  // Controller: next state, datapath register updates and handshake outputs.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    Stall    = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state_q)
      IDLE: begin
        // Stall must rise in the accept cycle itself so the MUL stays in EX.
        if (Start && !Flush) begin
          state_d  = RUN;
          mcand_d  = A;
          mplier_d = B;
          acc_d    = '0;
          cnt_d    = '0;
          Stall    = 1'b1;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (Flush) begin
          // Squashed MUL: drop the partial product, release the pipeline now.
          state_d = IDLE;
        end else begin
          Stall    = 1'b1;
          mcand_d  = step_mcand;
          mplier_d = step_mplier;
          acc_d    = step_acc;
          cnt_d    = cnt_q + 1'b1;
          if (last_step) begin
            result_d = step_acc;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        // Completion is already architectural; Start and Flush are ignored here.
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Reset dominates everything, including the combinational stall request.
    if (Reset) begin
      Stall = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign Result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: table of directed products on UNROLL=1 and UNROLL=4
// instances, plus hand sequences for flush, flush-at-accept and mid-run reset.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, start1, start4;
  logic [31:0] a, b;
  logic        stall1, busy1, done1, stall4, busy4, done4;
  logic [31:0] res1, res4;

  logic        sel;  // 0 -> UNROLL=1 instance, 1 -> UNROLL=4 instance
  logic        stall_m, busy_m, done_m;
  logic [31:0] res_m;

  int total = 0;
  int bad   = 0;
  logic [31:0] last1 = 32'd0;
  logic [31:0] last4 = 32'd0;

  mul_sequencer #(.WIDTH(32), .UNROLL(1)) u_mul1 (
    .Clk(clk), .Reset(reset), .Start(start1), .Flush(flush), .A(a), .B(b),
    .Stall(stall1), .Busy(busy1), .Done(done1), .Result(res1)
  );

  mul_sequencer #(.WIDTH(32), .UNROLL(4)) u_mul4 (
    .Clk(clk), .Reset(reset), .Start(start4), .Flush(flush), .A(a), .B(b),
    .Stall(stall4), .Busy(busy4), .Done(done4), .Result(res4)
  );

  always_comb begin
    stall_m = sel ? stall4 : stall1;
    busy_m  = sel ? busy4  : busy1;
    done_m  = sel ? done4  : done1;
    res_m   = sel ? res4   : res1;
  end

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp;
    logic        u4;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample once settled.
  task automatic cyc(input logic st, input logic fl, input logic rs);
    @(negedge clk);
    start1 = sel ? 1'b0 : st;
    start4 = sel ? st : 1'b0;
    flush  = fl;
    reset  = rs;
    #1;
  endtask

  // Full MUL with Start held high through DONE; n = WIDTH/UNROLL.
  task automatic run_mul(input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] exp, input int n, input string tag);
    int stall_cnt = 0, busy_cnt = 0, done_cnt = 0, done_at = -1;
    int both = 0, stall_done = 0, hold_bad = 0;
    logic [31:0] prev;
    prev = sel ? last4 : last1;
    a = va;
    b = vb;
    for (int k = 0; k <= n + 1; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (k == 0) chk({tag, "_idle_busy"}, {31'd0, busy_m}, 32'd0);
      if (stall_m) stall_cnt++;
      if (busy_m) busy_cnt++;
      if (done_m) begin
        done_cnt++;
        done_at = k;
      end
      if (busy_m && done_m) both++;
      if (stall_m && done_m) stall_done++;
      if (k <= n && res_m !== prev) hold_bad++;
      if (k == n + 1) chk({tag, "_result"}, res_m, exp);
    end
    chk({tag, "_stall_cycles"}, stall_cnt, n + 1);
    chk({tag, "_busy_cycles"}, busy_cnt, n);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_at, n + 1);
    chk({tag, "_busy_and_done"}, both, 0);
    chk({tag, "_stall_in_done"}, stall_done, 0);
    chk({tag, "_result_hold"}, hold_bad, 0);
    if (sel) last4 = exp;
    else     last1 = exp;
  endtask

  initial begin
    int dcnt;
    vecs[0] = '{32'd6,        32'd7,        32'd42,        1'b0};
    vecs[1] = '{32'd3,        32'd5,        32'd15,        1'b0};
    vecs[2] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,  1'b0};
    vecs[3] = '{32'h00010000, 32'h00010000, 32'h00000000,  1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  1'b0};
    vecs[5] = '{32'd0,        32'd1234,     32'd0,         1'b0};
    vecs[6] = '{32'h12345678, 32'h9ABCDEF0, 32'h242D2080,  1'b1};
    vecs[7] = '{32'd7,        32'd9,        32'd63,        1'b1};
    vecs[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  1'b1};

    sel = 1'b0; reset = 1'b1; flush = 1'b0; start1 = 1'b0; start4 = 1'b0;
    a = 32'd0; b = 32'd0;

    // Reset with Start asserted: everything must read zero.
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("reset_stall", {31'd0, stall1}, 32'd0);
    chk("reset_busy",  {31'd0, busy1},  32'd0);
    chk("reset_done",  {31'd0, done1},  32'd0);
    chk("reset_result", res1, 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("reset_start_ignored", {31'd0, busy1}, 32'd0);

    // Table: back-to-back products per instance, idle cycle between instances.
    for (int i = 0; i < 9; i++) begin
      if (i > 0 && vecs[i].u4 != vecs[i-1].u4) cyc(1'b0, 1'b0, 1'b0);
      sel = vecs[i].u4;
      run_mul(vecs[i].va, vecs[i].vb, vecs[i].exp, vecs[i].u4 ? 8 : 32,
              $sformatf("vec%0d", i));
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("tail_idle_busy", {31'd0, busy_m}, 32'd0);
    chk("tail_idle_done", {31'd0, done_m}, 32'd0);
    sel = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Flush in RUN cycle 10.
    a = 32'd100; b = 32'd200;
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("flush_stall_low", {31'd0, stall1}, 32'd0);
    chk("flush_busy_still", {31'd0, busy1}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("flush_idle_busy",  {31'd0, busy1},  32'd0);
    chk("flush_idle_stall", {31'd0, stall1}, 32'd0);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (done1) dcnt++;
    end
    chk("flush_no_done", dcnt, 0);
    chk("flush_result_kept", res1, last1);
    run_mul(32'd11, 32'd13, 32'd143, 32, "after_flush");
    cyc(1'b0, 1'b0, 1'b0);

    // Flush coinciding with the accept.
    cyc(1'b1, 1'b1, 1'b0);
    chk("flush_accept_stall", {31'd0, stall1}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("flush_accept_busy", {31'd0, busy1}, 32'd0);

    // Reset at RUN cycle 20, held one more cycle alongside Start.
    a = 32'd9; b = 32'd9;
    for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, 1'b0);
    chk("pre_reset_busy", {31'd0, busy1}, 32'd1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("midrst_stall",  {31'd0, stall1}, 32'd0);
    chk("midrst_busy",   {31'd0, busy1},  32'd0);
    chk("midrst_done",   {31'd0, done1},  32'd0);
    chk("midrst_result", res1, 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("midrst_start_ignored", {31'd0, busy1}, 32'd0);
    last1 = 32'd0;
    run_mul(32'd6, 32'd7, 32'd42, 32, "after_reset");
    cyc(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
